// File: rtl/rgbled_rx.sv
`default_nettype none
// ============================================================================
// Module   : rgbled_rx
// Function : WS2812-style single-wire LED stream decoder (24-bit GRB words,
//            frame end on long low gap, protocol error detection)
// Revision : 1.0
// ============================================================================
module rgbled_rx #(
    parameter int MinHighCycles   = 4,
    parameter int OneThreshCycles = 18,
    parameter int MaxHighCycles   = 30,
    parameter int ResetCycles     = 1500,
    parameter int CntWidth        = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        din_i,
    output logic [23:0] data_o,
    output logic        valid_o,
    output logic        frame_end_o,
    output logic [15:0] frame_words_o,
    output logic        err_o,
    output logic        locked_o
);

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } state_t;

    localparam logic [CntWidth-1:0] MIN_HIGH   = CntWidth'(MinHighCycles);
    localparam logic [CntWidth-1:0] ONE_THRESH = CntWidth'(OneThreshCycles);
    localparam logic [CntWidth-1:0] MAX_HIGH   = CntWidth'(MaxHighCycles);
    localparam logic [CntWidth-1:0] RESET_LEN  = CntWidth'(ResetCycles);
    localparam logic [CntWidth-1:0] CNT_ONE    = CntWidth'(1);

    logic                s_meta;
    logic                s;
    state_t              state;
    state_t              state_nx;
    logic [CntWidth-1:0] cnt;
    logic [CntWidth-1:0] cnt_nx;
    logic [CntWidth-1:0] cnt_inc;
    logic [4:0]          bit_cnt;
    logic [4:0]          bit_cnt_nx;
    logic [4:0]          bit_cnt_inc;
    logic [23:0]         sreg;
    logic [23:0]         sreg_nx;
    logic [23:0]         shifted;
    logic [23:0]         data_nx;
    logic [15:0]         word_cnt;
    logic [15:0]         word_cnt_nx;
    logic [15:0]         word_inc;
    logic [15:0]         frame_words_nx;
    logic                valid_nx;
    logic                frame_end_nx;
    logic                err_nx;
    logic                locked_nx;

    assign cnt_inc     = (cnt == '1) ? cnt : cnt + CNT_ONE;
    assign bit_cnt_inc = bit_cnt + 5'd1;
    assign shifted     = {sreg[22:0], (cnt >= ONE_THRESH)};
    assign word_inc    = (word_cnt == 16'hFFFF) ? word_cnt : word_cnt + 16'd1;
    assign locked_nx   = (state_nx != RESYNC);

    always_comb begin
        state_nx       = state;
        cnt_nx         = cnt;
        bit_cnt_nx     = bit_cnt;
        sreg_nx        = sreg;
        word_cnt_nx    = word_cnt;
        data_nx        = data_o;
        frame_words_nx = frame_words_o;
        valid_nx       = 1'b0;
        frame_end_nx   = 1'b0;
        err_nx         = 1'b0;

        case (state)
            RESYNC: begin
                if (s) begin
                    cnt_nx = '0;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= RESET_LEN) begin
                        state_nx = IDLE;
                    end
                end
            end
            IDLE: begin
                if (s) begin
                    state_nx = HIGH;
                    cnt_nx   = CNT_ONE;
                end
            end
            HIGH: begin
                if (s) begin
                    if (cnt_inc > MAX_HIGH) begin
                        err_nx      = 1'b1;
                        bit_cnt_nx  = '0;
                        sreg_nx     = '0;
                        word_cnt_nx = '0;
                        cnt_nx      = '0;
                        state_nx    = RESYNC;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end else if (cnt < MIN_HIGH) begin
                    err_nx      = 1'b1;
                    bit_cnt_nx  = '0;
                    sreg_nx     = '0;
                    word_cnt_nx = '0;
                    cnt_nx      = '0;
                    state_nx    = RESYNC;
                end else begin
                    sreg_nx = shifted;
                    if (bit_cnt_inc == 5'd24) begin
                        data_nx     = shifted;
                        valid_nx    = 1'b1;
                        word_cnt_nx = word_inc;
                        bit_cnt_nx  = '0;
                    end else begin
                        bit_cnt_nx = bit_cnt_inc;
                    end
                    cnt_nx   = CNT_ONE;
                    state_nx = LOW;
                end
            end
            LOW: begin
                if (s) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = HIGH;
                end else begin
                    cnt_nx = cnt_inc;
                    if (cnt_inc >= RESET_LEN) begin
                        frame_end_nx   = 1'b1;
                        frame_words_nx = word_cnt;
                        word_cnt_nx    = '0;
                        // A gap in the middle of a word truncates it.
                        if (bit_cnt != 5'd0) begin
                            err_nx     = 1'b1;
                            bit_cnt_nx = '0;
                            sreg_nx    = '0;
                        end
                        state_nx = IDLE;
                    end
                end
            end
            default: begin
                state_nx = RESYNC;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_meta        <= 1'b0;
            s             <= 1'b0;
            state         <= RESYNC;
            cnt           <= '0;
            bit_cnt       <= '0;
            sreg          <= '0;
            word_cnt      <= '0;
            data_o        <= '0;
            valid_o       <= 1'b0;
            frame_end_o   <= 1'b0;
            frame_words_o <= '0;
            err_o         <= 1'b0;
            locked_o      <= 1'b0;
        end else begin
            s_meta        <= din_i;
            s             <= s_meta;
            state         <= state_nx;
            cnt           <= cnt_nx;
            bit_cnt       <= bit_cnt_nx;
            sreg          <= sreg_nx;
            word_cnt      <= word_cnt_nx;
            data_o        <= data_nx;
            valid_o       <= valid_nx;
            frame_end_o   <= frame_end_nx;
            frame_words_o <= frame_words_nx;
            err_o         <= err_nx;
            locked_o      <= locked_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgbled_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgbled_rx
// Function : self-checking bench for rgbled_rx
// Revision : 1.0
// ============================================================================
module tb_rgbled_rx;

    logic        clk_i;
    logic        rst_ni;
    logic        din_i;
    logic [23:0] data_o;
    logic        valid_o;
    logic        frame_end_o;
    logic [15:0] frame_words_o;
    logic        err_o;
    logic        locked_o;

    rgbled_rx dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .din_i         (din_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .frame_end_o   (frame_end_o),
        .frame_words_o (frame_words_o),
        .err_o         (err_o),
        .locked_o      (locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int          hi1;
        int          hi0;
        logic [23:0] word;
    } vec_t;

    int          tests;
    int          fails;
    int          n_valid;
    int          n_fe;
    int          n_err;
    logic [15:0] last_fw;
    logic        fe_err;
    logic [23:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid_o pulse must match the oldest expected word.
    always @(negedge clk_i) begin
        if (valid_o) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid actual=%h expected=none", data_o);
            end else begin
                check("data_o", {8'h00, data_o}, {8'h00, exp_q.pop_front()});
            end
        end
        if (frame_end_o) begin
            n_fe++;
            last_fw = frame_words_o;
            fe_err  = err_o;
        end
        if (err_o) n_err++;
    end

    // Tasks start and end 2 time units after a rising edge.
    task automatic send_bit(input int hi, input int lo);
        din_i = 1'b1;
        repeat (hi) @(posedge clk_i);
        #2 din_i = 1'b0;
        repeat (lo) @(posedge clk_i);
        #2;
    endtask

    task automatic send_word(input logic [23:0] w, input int hi1, input int hi0, input bit push);
        int hi;
        if (push) exp_q.push_back(w);
        for (int i = 23; i >= 0; i--) begin
            hi = w[i] ? hi1 : hi0;
            send_bit(hi, 38 - hi);
        end
    endtask

    task automatic gap();
        din_i = 1'b0;
        repeat (1600) @(posedge clk_i);
        #2;
    endtask

    task automatic wait_lock();
        int k;
        k = 0;
        while (!locked_o && k < 3000) begin
            @(posedge clk_i);
            k++;
        end
        #2;
        check("locked_o_rise", {31'd0, locked_o}, 32'd1);
    endtask

    vec_t vecs[5];
    int   v0, f0, e0;

    initial begin
        tests   = 0;
        fails   = 0;
        n_valid = 0;
        n_fe    = 0;
        n_err   = 0;
        last_fw = '0;
        fe_err  = 1'b0;
        vecs[0] = '{24, 9,  24'h5A5A5A};
        vecs[1] = '{18, 17, 24'h96C3E1};
        vecs[2] = '{30, 4,  24'hF0F00F};
        vecs[3] = '{18, 4,  24'h800001};
        vecs[4] = '{30, 17, 24'h7E7E7E};

        din_i  = 1'b0;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #2;
        check("rst_data_o", {8'h00, data_o}, 32'd0);
        check("rst_valid_o", {31'd0, valid_o}, 32'd0);
        check("rst_frame_end_o", {31'd0, frame_end_o}, 32'd0);
        check("rst_frame_words_o", {16'd0, frame_words_o}, 32'd0);
        check("rst_err_o", {31'd0, err_o}, 32'd0);
        check("rst_locked_o", {31'd0, locked_o}, 32'd0);

        // Lock after ResetCycles of low, silently.
        rst_ni = 1'b1;
        repeat (1490) @(posedge clk_i);
        #1 check("locked_early", {31'd0, locked_o}, 32'd0);
        wait_lock();
        check("lock_no_fe", n_fe, 0);
        check("lock_no_err", n_err, 0);

        // Single word with latency check on the last bit.
        exp_q.push_back(24'hA53C0F);
        for (int i = 23; i >= 1; i--) send_bit(24'hA53C0F >> i & 1 ? 24 : 9, 24'hA53C0F >> i & 1 ? 14 : 29);
        din_i = 1'b1;
        repeat (24) @(posedge clk_i);
        #2 din_i = 1'b0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 check("valid_before_lat", {31'd0, valid_o}, 32'd0);
        @(posedge clk_i);
        #1 check("valid_at_lat", {31'd0, valid_o}, 32'd1);
        #1;
        gap();
        check("w1_valid_cnt", n_valid, 1);
        check("w1_fe_cnt", n_fe, 1);
        check("w1_frame_words", {16'd0, last_fw}, 32'd1);
        check("w1_err_cnt", n_err, 0);

        // Three words back-to-back.
        send_word(24'hFFFFFF, 24, 9, 1'b1);
        send_word(24'h000000, 24, 9, 1'b1);
        send_word(24'h123456, 24, 9, 1'b1);
        gap();
        check("w3_valid_cnt", n_valid, 4);
        check("w3_frame_words", {16'd0, last_fw}, 32'd3);
        check("w3_err_cnt", n_err, 0);

        // Partial word then gap: frame end and error together.
        v0 = n_valid; f0 = n_fe; e0 = n_err;
        for (int i = 0; i < 10; i++) send_bit(24, 14);
        gap();
        check("part_valid", n_valid - v0, 0);
        check("part_fe", n_fe - f0, 1);
        check("part_err", n_err - e0, 1);
        check("part_fe_with_err", {31'd0, fe_err}, 32'd1);
        check("part_frame_words", {16'd0, last_fw}, 32'd0);

        // Glitch: lose lock, ignore data until a full low gap.
        v0 = n_valid; f0 = n_fe; e0 = n_err;
        for (int i = 0; i < 5; i++) send_bit(9, 29);
        send_bit(2, 30);
        check("glitch_err", n_err - e0, 1);
        check("glitch_unlocked", {31'd0, locked_o}, 32'd0);
        send_word(24'h654321, 24, 9, 1'b0);
        check("resync_no_valid", n_valid - v0, 0);
        gap();
        check("resync_no_fe", n_fe - f0, 0);
        check("resync_err_once", n_err - e0, 1);
        wait_lock();
        send_word(24'hC0FFEE, 24, 9, 1'b1);
        gap();
        check("relock_valid", n_valid - v0, 1);
        check("relock_frame_words", {16'd0, last_fw}, 32'd1);

        // 40-cycle high: error on the 31st synchronised high cycle.
        e0 = n_err; f0 = n_fe;
        din_i = 1'b1;
        repeat (32) @(posedge clk_i);
        #1 check("long_no_err_yet", {31'd0, err_o}, 32'd0);
        @(posedge clk_i);
        #1 check("long_err", {31'd0, err_o}, 32'd1);
        repeat (7) @(posedge clk_i);
        #2 din_i = 1'b0;
        gap();
        check("long_err_once", n_err - e0, 1);
        check("long_no_fe", n_fe - f0, 0);
        wait_lock();

        // Pulse-width boundary table.
        foreach (vecs[k]) begin
            v0 = n_valid; e0 = n_err;
            send_word(vecs[k].word, vecs[k].hi1, vecs[k].hi0, 1'b1);
            gap();
            check($sformatf("vec%0d_valid", k), n_valid - v0, 1);
            check($sformatf("vec%0d_err", k), n_err - e0, 0);
            check($sformatf("vec%0d_frame_words", k), {16'd0, last_fw}, 32'd1);
        end

        // Reset mid-word returns everything to reset values.
        for (int i = 0; i < 10; i++) send_bit(24, 14);
        rst_ni = 1'b0;
        #1;
        check("midrst_data_o", {8'h00, data_o}, 32'd0);
        check("midrst_locked_o", {31'd0, locked_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1'b1;
        gap();
        wait_lock();
        send_word(24'h0BEEF1, 24, 9, 1'b1);
        gap();
        check("midrst_frame_words", {16'd0, last_fw}, 32'd1);

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
